serial_addsub_core: RTL and testbench

Parametrised bit-serial adder/subtractor with a load/start/done handshake. It processes WIDTH-bit operands LSB-first, one bit per clock, through a two-state carry Mealy machine. It reports a WIDTH-bit result, carry/no-borrow and signed overflow. It is the general-width, add/sub-capable, handshaked successor to the fixed 8-bit serial adder datapath.

---
 rtl/serial_addsub_core.sv | 128 ++++++++++++
 tb/tb_serial_addsub_core.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_core.sv
// Bit-serial WIDTH-bit adder/subtractor with a start/done handshake.
// Operands are consumed LSB-first, one bit per clock, through a two-state carry Mealy machine.
module serial_addsub_core #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out,
  output logic             ovf,
  output logic             s_bit
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic {C0, C1} carry_t;

  state_t           state_q, state_d;
  carry_t           carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic a_bit, b_bit, cin;

  assign a_bit = a_q[0];
  assign b_bit = b_q[0];
  assign cin   = (carry_q == C1);

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      carry_q <= C0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    s_bit   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B and preload the carry.
          a_d     = A_i;
          b_d     = mode ? ~B_i : B_i;
          carry_d = mode ? C1 : C0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        s_bit = a_bit ^ b_bit ^ cin;
        if (a_bit && b_bit)
          carry_d = C1;
        else if (!a_bit && !b_bit)
          carry_d = C0;
        else
          carry_d = carry_q;

        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {s_bit, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);

        if (cnt_q == LAST_BIT) begin
          // On the MSB, cin is the carry into it and carry_d the carry out.
          state_d = IDLE;
          sum_d   = res_d;
          cout_d  = (carry_d == C1);
          ovf_d   = cin ^ (carry_d == C1);
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign sum_o = sum_q;
  assign c_out = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub_core.sv
// Self-checking bench for serial_addsub_core at WIDTH=8 and WIDTH=3,
// using directed cases plus a random sweep against an arithmetic reference model.
module tb_serial_addsub_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, start3;
  logic       mode;
  logic [7:0] A, B;

  logic       busy8, done8, cout8, ovf8, sbit8;
  logic [7:0] sum8;
  logic       busy3, done3, cout3, ovf3, sbit3;
  logic [2:0] sum3;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] prev8 = 8'h00;
  logic [7:0] prev3 = 8'h00;

  always #5 clk = ~clk;

  serial_addsub_core #(.WIDTH(8)) u8 (
    .i_clk(clk), .reset(reset), .start(start8), .mode(mode),
    .A_i(A), .B_i(B), .busy(busy8), .done(done8), .sum_o(sum8),
    .c_out(cout8), .ovf(ovf8), .s_bit(sbit8)
  );

  serial_addsub_core #(.WIDTH(3)) u3 (
    .i_clk(clk), .reset(reset), .start(start3), .mode(mode),
    .A_i(A[2:0]), .B_i(B[2:0]), .busy(busy3), .done(done3), .sum_o(sum3),
    .c_out(cout3), .ovf(ovf3), .s_bit(sbit3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, c_out, sum[7:0]} computed from plain integer arithmetic.
  function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                       input logic m);
    int av, bv, sa, sb, full, sres, half;
    logic [7:0] s;
    logic co, ov;
    half = 1 << (w - 1);
    av = int'(a) & ((1 << w) - 1);
    bv = int'(b) & ((1 << w) - 1);
    sa = (av >= half) ? av - 2 * half : av;
    sb = (bv >= half) ? bv - 2 * half : bv;
    if (!m) begin
      full = av + bv;
      co   = (full >= 2 * half);
      sres = sa + sb;
    end else begin
      full = av - bv;
      co   = (av >= bv);
      sres = sa - sb;
    end
    s  = 8'(full & ((1 << w) - 1));
    ov = (sres < -half) || (sres > half - 1);
    return {ov, co, s};
  endfunction

  function automatic logic o_busy(input int w);  return (w == 3) ? busy3 : busy8;  endfunction
  function automatic logic o_done(input int w);  return (w == 3) ? done3 : done8;  endfunction
  function automatic logic o_cout(input int w);  return (w == 3) ? cout3 : cout8;  endfunction
  function automatic logic o_ovf(input int w);   return (w == 3) ? ovf3  : ovf8;   endfunction
  function automatic logic o_sbit(input int w);  return (w == 3) ? sbit3 : sbit8;  endfunction
  function automatic logic [7:0] o_sum(input int w);
    return (w == 3) ? {5'b0, sum3} : sum8;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 3) start3 = v; else start8 = v;
  endtask

  // Entered just after a negedge. Leaves at the negedge of the done cycle
  // (chain=1) or one cycle later after checking the pulse fell (chain=0).
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic m,
                        input bit inject, input bit chain, input bit verbose);
    logic [9:0] exp;
    logic [7:0] prev;
    exp  = model(w, a, b, m);
    prev = (w == 3) ? prev3 : prev8;
    A = a; B = b; mode = m;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    A = ~a; B = a ^ b; mode = ~m;
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      chk("busy_run", 32'(o_busy(w)), 32'd1);
      chk("done_run", 32'(o_done(w)), 32'd0);
      chk("s_bit", 32'(o_sbit(w)), 32'(exp[i]));
      chk("sum_hold", 32'(o_sum(w)), 32'(prev));
      if (inject && i == 2) begin
        A = 8'hC3; B = 8'h3C;
        set_start(w, 1'b1);
      end
      if (inject && i == 4) set_start(w, 1'b0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(o_done(w)), 32'd1);
    chk("busy_done", 32'(o_busy(w)), 32'd0);
    chk("sum", 32'(o_sum(w)), 32'(exp[7:0]));
    chk("c_out", 32'(o_cout(w)), 32'(exp[8]));
    chk("ovf", 32'(o_ovf(w)), 32'(exp[9]));
    if (w == 3) prev3 = exp[7:0]; else prev8 = exp[7:0];
    if (verbose)
      $display("op w=%0d %s a=%02h b=%02h -> sum=%02h c=%0b ovf=%0b", w, m ? "sub" : "add",
               a, b, o_sum(w), o_cout(w), o_ovf(w));
    if (!chain) begin
      @(negedge clk);
      chk("done_fall", 32'(o_done(w)), 32'd0);
      chk("sum_keep", 32'(o_sum(w)), 32'(exp[7:0]));
    end
  endtask

  initial begin
    reset = 1'b1; start8 = 1'b0; start3 = 1'b0; mode = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_sum8", 32'(sum8), 32'd0);
    chk("rst_cout8", 32'({cout8, ovf8, sbit8}), 32'd0);
    chk("rst_all3", 32'({busy3, done3, sum3, cout3, ovf3, sbit3}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(8, 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(8, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(8, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op(8, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);

    // Mid-run start is ignored; then a back-to-back start in the done cycle.
    run_op(8, 8'h37, 8'h49, 1'b0, 1'b1, 1'b1, 1'b1);
    run_op(8, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort mid-run with reset.
    A = 8'h66; B = 8'h11; mode = 1'b0;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_flags", 32'({cout8, ovf8}), 32'd0);
    $display("reset asserted mid-run: busy=%0b sum=%02h", busy8, sum8);
    prev8 = 8'h00; prev3 = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'({done8, busy8}), 32'd0);
    end
    run_op(8, 8'h05, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1);

    run_op(3, 8'h07, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(3, 8'h03, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(3, 8'h04, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 1000; k++) begin
      run_op(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0);
    end
    $display("random sweep width 8 complete: 1000 ops");
    for (int k = 0; k < 200; k++) begin
      run_op(3, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)), 1'($urandom),
             1'b0, 1'($urandom), 1'b0);
    end
    $display("random sweep width 3 complete: 200 ops");
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
